// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Holds one instruction, captures the data SRAM answer in the first MEM cycle,
// extracts/extends load data, and forwards results to write-back and decode.
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ex_mem_valid,
  output logic         mem_allowin,
  input  logic [189:0] ex_mem_bus,
  input  logic [31:0]  data_sram_rdata,
  output logic         mem_wb_valid,
  input  logic         wb_allowin,
  output logic [183:0] mem_wb_bus,
  output logic [37:0]  mem_id_bus,
  output logic         mem_exc,
  input  logic         wb_flush
);

  logic         mem_valid_reg;
  logic         mem_valid_next;
  logic [189:0] bus_reg;
  logic [31:0]  rdata_buf_reg;
  logic         rdata_vld_reg;
  logic         mem_ready_go;
  logic         accept;

  // Decoded fields of the held execute-to-memory bus
  logic         gr_we;
  logic         res_from_mem;
  logic [2:0]   mem_type;
  logic [1:0]   addr_low2;
  logic [4:0]   dest;
  logic [31:0]  pc;
  logic [31:0]  inst;
  logic [31:0]  final_result;
  logic         csr_we;
  logic         csr_re;
  logic [13:0]  csr_num;
  logic [31:0]  csr_wmask;
  logic [31:0]  csr_wvalue;
  logic         ertn;
  logic         syscall;

  assign {gr_we, res_from_mem, mem_type, addr_low2, dest, pc, inst, final_result,
          csr_we, csr_re, csr_num, csr_wmask, csr_wvalue, ertn, syscall} = bus_reg;

  // Data access always completes within the stage, so it never holds back.
  assign mem_ready_go = 1'b1;
  assign mem_allowin  = ~mem_valid_reg | (wb_allowin & mem_ready_go);
  assign mem_wb_valid = mem_valid_reg & ~wb_flush;
  assign accept       = ex_mem_valid & mem_allowin & ~wb_flush;

  // Next occupancy: a flush empties the stage ahead of any incoming instruction
  always_comb begin
    mem_valid_next = mem_valid_reg;
    if (wb_flush) begin
      mem_valid_next = 1'b0;
    end else if (mem_allowin) begin
      mem_valid_next = ex_mem_valid;
    end
  end

  // Occupancy flag and the held instruction bus
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_reg <= 1'b0;
      bus_reg       <= '0;
    end else begin
      mem_valid_reg <= mem_valid_next;
      if (accept) begin
        bus_reg <= ex_mem_bus;
      end
    end
  end

  // SRAM answers only in the first MEM cycle; keep that word for later stall cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_buf_reg <= '0;
      rdata_vld_reg <= 1'b0;
    end else if (accept) begin
      rdata_vld_reg <= 1'b0;
    end else if (mem_valid_reg && !rdata_vld_reg) begin
      rdata_buf_reg <= data_sram_rdata;
      rdata_vld_reg <= 1'b1;
    end
  end

  logic [31:0] raw_data;
  logic [7:0]  byte_lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_result;
  logic [31:0] mem_result;

  assign raw_data = rdata_vld_reg ? rdata_buf_reg : data_sram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = raw_data[gi*8 +: 8];
    end
  endgenerate

  // Halfword selection ignores addr_low2[0]; misaligned halfwords are not trapped here.
  assign sel_byte = byte_lane[addr_low2];
  assign sel_half = addr_low2[1] ? raw_data[31:16] : raw_data[15:0];

  // Load extraction and extension; unknown codes behave as a full word load
  always_comb begin
    load_result = raw_data;
    case (mem_type)
      3'b001:  load_result = {{24{sel_byte[7]}}, sel_byte};
      3'b010:  load_result = {{16{sel_half[15]}}, sel_half};
      3'b011:  load_result = {24'd0, sel_byte};
      3'b100:  load_result = {16'd0, sel_half};
      default: load_result = raw_data;
    endcase
  end

  assign mem_result = res_from_mem ? load_result : final_result;

  assign mem_wb_bus = {gr_we, dest, pc, inst, mem_result, csr_we, csr_re, csr_num,
                       csr_wmask, csr_wvalue, ertn, syscall};
  assign mem_id_bus = {mem_valid_reg & gr_we, dest, mem_result};
  assign mem_exc    = mem_valid_reg & (ertn | syscall);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table vectors for load extraction, hand sequences for stall,
// flush and reset corners, and a randomized run against a behavioural model.
module tb_mem_stage;

  typedef struct packed {
    logic        gr_we;
    logic        res_from_mem;
    logic [2:0]  mem_type;
    logic [1:0]  addr_low2;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] final_result;
    logic        csr_we;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        syscall;
  } ex_t;

  typedef struct {
    logic [2:0]  mt;
    logic [1:0]  al2;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ex_mem_valid;
  logic         mem_allowin;
  logic [189:0] ex_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic         mem_wb_valid;
  logic         wb_allowin;
  logic [183:0] mem_wb_bus;
  logic [37:0]  mem_id_bus;
  logic         mem_exc;
  logic         wb_flush;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ex_mem_valid    (ex_mem_valid),
    .mem_allowin     (mem_allowin),
    .ex_mem_bus      (ex_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_wb_valid    (mem_wb_valid),
    .wb_allowin      (wb_allowin),
    .mem_wb_bus      (mem_wb_bus),
    .mem_id_bus      (mem_id_bus),
    .mem_exc         (mem_exc),
    .wb_flush        (wb_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [183:0] act, input logic [183:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Step to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference load semantics written as plain integer arithmetic
  function automatic logic [31:0] load_ref(input logic [2:0] t, input logic [1:0] a,
                                           input logic [31:0] raw);
    longint b;
    longint h;
    longint v;
    b = (longint'(raw) >> (8 * int'(a))) & 255;
    h = (longint'(raw) >> (a[1] ? 16 : 0)) & 65535;
    case (t)
      3'd1:    v = (b >= 128) ? b - 256 : b;
      3'd2:    v = (h >= 32768) ? h - 65536 : h;
      3'd3:    v = b;
      3'd4:    v = h;
      default: v = longint'(raw);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [183:0] wb_exp(input ex_t e, input logic [31:0] r);
    return {e.gr_we, e.dest, e.pc, e.inst, r, e.csr_we, e.csr_re, e.csr_num,
            e.csr_wmask, e.csr_wvalue, e.ertn, e.syscall};
  endfunction

  function automatic ex_t rand_ex();
    ex_t e;
    e.gr_we        = 1'($urandom_range(0, 1));
    e.res_from_mem = 1'($urandom_range(0, 1));
    e.mem_type     = 3'($urandom_range(0, 7));
    e.addr_low2    = 2'($urandom_range(0, 3));
    e.dest         = 5'($urandom_range(0, 31));
    e.pc           = $urandom;
    e.inst         = $urandom;
    e.final_result = $urandom;
    e.csr_we       = 1'($urandom_range(0, 1));
    e.csr_re       = 1'($urandom_range(0, 1));
    e.csr_num      = 14'($urandom_range(0, 16383));
    e.csr_wmask    = $urandom;
    e.csr_wvalue   = $urandom;
    e.ertn         = ($urandom_range(0, 15) == 0);
    e.syscall      = ($urandom_range(0, 15) == 0);
    return e;
  endfunction

  vec_t vecs[12];
  ex_t  e;
  ex_t  e2;
  ex_t  m_ins;
  logic m_valid;
  logic m_first;
  logic [31:0] m_raw;
  logic [31:0] m_res;
  logic exp_allowin;

  initial begin
    vecs[0]  = '{3'd1, 2'd3, 32'h80123456, 32'hFFFFFF80};
    vecs[1]  = '{3'd3, 2'd3, 32'h80123456, 32'h00000080};
    vecs[2]  = '{3'd4, 2'd2, 32'hBEEF1234, 32'h0000BEEF};
    vecs[3]  = '{3'd2, 2'd0, 32'h00008001, 32'hFFFF8001};
    vecs[4]  = '{3'd0, 2'd0, 32'h11223344, 32'h11223344};
    vecs[5]  = '{3'd1, 2'd1, 32'h12347F56, 32'h0000007F};
    vecs[6]  = '{3'd2, 2'd3, 32'h8000FFFF, 32'hFFFF8000};
    vecs[7]  = '{3'd4, 2'd1, 32'h8000FFFF, 32'h0000FFFF};
    vecs[8]  = '{3'd5, 2'd2, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[9]  = '{3'd7, 2'd1, 32'h01020384, 32'h01020384};
    vecs[10] = '{3'd3, 2'd0, 32'hFFFFFF00, 32'h00000000};
    vecs[11] = '{3'd1, 2'd2, 32'h00FE0000, 32'hFFFFFFFE};

    resetn = 1'b0; ex_mem_valid = 1'b0; ex_mem_bus = '0; data_sram_rdata = '0;
    wb_allowin = 1'b1; wb_flush = 1'b0;

    // Reset state
    cyc(); cyc();
    resetn = 1'b1;
    cyc();
    chk("reset_allowin", 184'(mem_allowin), 184'(1));
    chk("reset_wb_valid", 184'(mem_wb_valid), 184'(0));
    chk("reset_id_bus", 184'(mem_id_bus), 184'(0));
    chk("reset_wb_bus", mem_wb_bus, 184'(0));
    chk("reset_exc", 184'(mem_exc), 184'(0));

    // Table-driven load extraction
    for (int i = 0; i < 12; i++) begin
      e = rand_ex();
      e.gr_we = 1'b1; e.res_from_mem = 1'b1; e.ertn = 1'b0; e.syscall = 1'b0;
      e.mem_type = vecs[i].mt; e.addr_low2 = vecs[i].al2; e.dest = 5'(i + 1);
      ex_mem_bus = e; ex_mem_valid = 1'b1; wb_allowin = 1'b1;
      cyc();
      ex_mem_valid = 1'b0; data_sram_rdata = vecs[i].rdata;
      #1;
      $display("vec %0d type=%0d al2=%0d rdata=%08h result=%08h", i, vecs[i].mt,
               vecs[i].al2, vecs[i].rdata, mem_wb_bus[113:82]);
      chk("vec_wb_valid", 184'(mem_wb_valid), 184'(1));
      chk("vec_wb_bus", mem_wb_bus, wb_exp(e, vecs[i].exp));
      chk("vec_id_bus", 184'(mem_id_bus), 184'({1'b1, 5'(i + 1), vecs[i].exp}));
      cyc();
      chk("vec_drained", 184'(mem_wb_valid), 184'(0));
    end

    // Stall holds the first-cycle read data
    e = rand_ex();
    e.res_from_mem = 1'b1; e.mem_type = 3'd0; e.addr_low2 = 2'd0; e.ertn = 1'b0; e.syscall = 1'b0;
    ex_mem_bus = e; ex_mem_valid = 1'b1; wb_allowin = 1'b0;
    cyc();
    ex_mem_valid = 1'b0; data_sram_rdata = 32'h11223344;
    #1;
    chk("stall_first", 184'(mem_wb_bus[113:82]), 184'(32'h11223344));
    for (int k = 0; k < 3; k++) begin
      cyc();
      data_sram_rdata = 32'hDEADBEEF;
      #1;
      $display("stall cycle %0d result=%08h allowin=%0d", k, mem_wb_bus[113:82], mem_allowin);
      chk("stall_result", 184'(mem_wb_bus[113:82]), 184'(32'h11223344));
      chk("stall_allowin", 184'(mem_allowin), 184'(0));
      chk("stall_valid", 184'(mem_wb_valid), 184'(1));
    end
    cyc();
    wb_allowin = 1'b1;
    #1;
    chk("handoff_allowin", 184'(mem_allowin), 184'(1));
    chk("handoff_bus", mem_wb_bus, wb_exp(e, 32'h11223344));
    cyc();
    chk("handoff_done", 184'(mem_wb_valid), 184'(0));

    // Non-load ALU result forwarding
    e = rand_ex();
    e.res_from_mem = 1'b0; e.final_result = 32'h0000ABCD; e.gr_we = 1'b1; e.dest = 5'd5;
    e.ertn = 1'b0; e.syscall = 1'b0;
    ex_mem_bus = e; ex_mem_valid = 1'b1;
    cyc();
    ex_mem_valid = 1'b0; data_sram_rdata = $urandom;
    #1;
    $display("alu result=%08h id_bus=%010h", mem_wb_bus[113:82], mem_id_bus);
    chk("alu_result", 184'(mem_wb_bus[113:82]), 184'(32'h0000ABCD));
    chk("alu_id_bus", 184'(mem_id_bus), 184'({1'b1, 5'd5, 32'h0000ABCD}));
    cyc();

    // Syscall present, then flush with a simultaneous incoming instruction
    e = rand_ex();
    e.syscall = 1'b1; e.ertn = 1'b0; e.gr_we = 1'b1;
    ex_mem_bus = e; ex_mem_valid = 1'b1; wb_allowin = 1'b0;
    cyc();
    ex_mem_valid = 1'b0;
    #1;
    chk("exc_before_flush", 184'(mem_exc), 184'(1));
    e2 = rand_ex();
    ex_mem_bus = e2; ex_mem_valid = 1'b1; wb_flush = 1'b1;
    #1;
    chk("flush_masks_valid", 184'(mem_wb_valid), 184'(0));
    cyc();
    wb_flush = 1'b0; ex_mem_valid = 1'b0;
    #1;
    $display("flush: wb_valid=%0d exc=%0d", mem_wb_valid, mem_exc);
    chk("flush_empty", 184'(mem_wb_valid), 184'(0));
    chk("flush_exc", 184'(mem_exc), 184'(0));
    chk("flush_bypass", 184'(mem_id_bus[37]), 184'(0));
    wb_allowin = 1'b1;

    // Asynchronous reset in the middle of a stall
    e = rand_ex();
    e.ertn = 1'b0; e.syscall = 1'b0;
    ex_mem_bus = e; ex_mem_valid = 1'b1; wb_allowin = 1'b0;
    cyc();
    ex_mem_valid = 1'b0;
    #1;
    chk("rst_stall_valid", 184'(mem_wb_valid), 184'(1));
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_async_valid", 184'(mem_wb_valid), 184'(0));
    chk("rst_async_allowin", 184'(mem_allowin), 184'(1));
    wb_allowin = 1'b1;
    cyc();
    resetn = 1'b1;
    #1;
    $display("reset mid-stall: wb_valid=%0d", mem_wb_valid);
    chk("rst_not_delivered", 184'(mem_wb_valid), 184'(0));

    // Randomized traffic against the behavioural model
    m_valid = 1'b0; m_first = 1'b0; m_raw = '0; m_ins = '0;
    for (int n = 0; n < 400; n++) begin
      cyc();
      e = rand_ex();
      ex_mem_bus = e;
      ex_mem_valid = ($urandom_range(0, 3) != 0);
      wb_allowin = ($urandom_range(0, 2) != 0);
      wb_flush = ($urandom_range(0, 11) == 0);
      data_sram_rdata = $urandom;
      #1;
      // The SRAM word belonging to an instruction is the one present in its first cycle
      if (m_valid && m_first) m_raw = data_sram_rdata;
      exp_allowin = !m_valid || wb_allowin;
      m_res = m_ins.res_from_mem ? load_ref(m_ins.mem_type, m_ins.addr_low2, m_raw)
                                 : m_ins.final_result;
      chk("rnd_allowin", 184'(mem_allowin), 184'(exp_allowin));
      chk("rnd_wb_valid", 184'(mem_wb_valid), 184'(m_valid && !wb_flush));
      chk("rnd_exc", 184'(mem_exc), 184'(m_valid && (m_ins.ertn || m_ins.syscall)));
      if (m_valid) begin
        chk("rnd_wb_bus", mem_wb_bus, wb_exp(m_ins, m_res));
        chk("rnd_id_bus", 184'(mem_id_bus), 184'({m_ins.gr_we, m_ins.dest, m_res}));
      end else begin
        chk("rnd_id_bypass", 184'(mem_id_bus[37]), 184'(0));
      end
      if (m_valid && wb_allowin && !wb_flush)
        $display("txn %0d pc=%08h result=%08h", n, m_ins.pc, m_res);
      // Advance the model across the coming edge
      if (ex_mem_valid && exp_allowin && !wb_flush) begin
        m_ins = e;
        m_first = 1'b1;
      end else begin
        m_first = 1'b0;
      end
      if (wb_flush) m_valid = 1'b0;
      else if (exp_allowin) m_valid = ex_mem_valid;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
